// File: rtl/alu_control_pipe_pkg.sv
// Shared ALU-control encodings: ALUop codes, LEGv8 opcodes and 4-bit control words.
package alu_control_pipe_pkg;

  localparam int unsigned OP_W   = 11;
  localparam int unsigned OPI_W  = 10;
  localparam int unsigned CTRL_W = 4;

  typedef enum logic [1:0] {
    ALUOP_LDST  = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_e;

  localparam logic [OP_W-1:0] OPC_ADD = 11'b10001011000;
  localparam logic [OP_W-1:0] OPC_SUB = 11'b11001011000;
  localparam logic [OP_W-1:0] OPC_AND = 11'b10001010000;
  localparam logic [OP_W-1:0] OPC_ORR = 11'b10101010000;
  localparam logic [OP_W-1:0] OPC_EOR = 11'b11001010000;
  localparam logic [OP_W-1:0] OPC_LSL = 11'b11010011011;
  localparam logic [OP_W-1:0] OPC_LSR = 11'b11010011010;

  localparam logic [OPI_W-1:0] OPI_ADDI = 10'b1001000100;
  localparam logic [OPI_W-1:0] OPI_SUBI = 10'b1101000100;
  localparam logic [OPI_W-1:0] OPI_ANDI = 10'b1001001000;
  localparam logic [OPI_W-1:0] OPI_ORRI = 10'b1011001000;

  localparam logic [CTRL_W-1:0] CTRL_AND     = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_ORR     = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_ADD     = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_LSL     = 4'b0011;
  localparam logic [CTRL_W-1:0] CTRL_LSR     = 4'b0100;
  localparam logic [CTRL_W-1:0] CTRL_SUB     = 4'b0110;
  localparam logic [CTRL_W-1:0] CTRL_PASSB   = 4'b0111;
  localparam logic [CTRL_W-1:0] CTRL_EOR     = 4'b1010;
  localparam logic [CTRL_W-1:0] CTRL_ILLEGAL = 4'b1111;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
  } ctrl_word_t;

endpackage

// File: rtl/alu_control_pipe_if.sv
// ID->EX decode handshake: request {ALUop, Opcode} in, control word out.
interface alu_control_pipe_if;
  import alu_control_pipe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        ALUop;
  logic [OP_W-1:0]   Opcode;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ALUCtrl;
  logic              illegal;

  modport master (
    output in_valid, ALUop, Opcode, out_ready,
    input  in_ready, out_valid, ALUCtrl, illegal
  );

  modport slave (
    input  in_valid, ALUop, Opcode, out_ready,
    output in_ready, out_valid, ALUCtrl, illegal
  );
endinterface

// File: rtl/alu_control_pipe_decode.sv
// Combinational {ALUop, Opcode} -> {ALUCtrl, illegal} decoder.
module alu_control_pipe_decode
  import alu_control_pipe_pkg::*;
#(
  parameter int unsigned EXT_OPS = 1
) (
  input  logic [1:0]      ALUop,
  input  logic [OP_W-1:0] Opcode,
  output ctrl_word_t      dec_c
);

  // Anything not matched below falls through to the illegal word.
  always_comb begin
    dec_c = '{ctrl: CTRL_ILLEGAL, illegal: 1'b1};
    case (aluop_e'(ALUop))
      ALUOP_LDST: dec_c = '{ctrl: CTRL_ADD,   illegal: 1'b0};
      ALUOP_CBZ:  dec_c = '{ctrl: CTRL_PASSB, illegal: 1'b0};
      ALUOP_RTYPE: begin
        case (Opcode)
          OPC_ADD: dec_c = '{ctrl: CTRL_ADD, illegal: 1'b0};
          OPC_SUB: dec_c = '{ctrl: CTRL_SUB, illegal: 1'b0};
          OPC_AND: dec_c = '{ctrl: CTRL_AND, illegal: 1'b0};
          OPC_ORR: dec_c = '{ctrl: CTRL_ORR, illegal: 1'b0};
          OPC_EOR: dec_c = '{ctrl: CTRL_EOR, illegal: 1'b0};
          OPC_LSL: dec_c = '{ctrl: CTRL_LSL, illegal: 1'b0};
          OPC_LSR: dec_c = '{ctrl: CTRL_LSR, illegal: 1'b0};
          default: ;
        endcase
      end
      ALUOP_ITYPE: begin
        // Opcode bit 0 is part of the immediate field for I-type.
        if (EXT_OPS != 0) begin
          case (Opcode[OP_W-1:1])
            OPI_ADDI: dec_c = '{ctrl: CTRL_ADD, illegal: 1'b0};
            OPI_SUBI: dec_c = '{ctrl: CTRL_SUB, illegal: 1'b0};
            OPI_ANDI: dec_c = '{ctrl: CTRL_AND, illegal: 1'b0};
            OPI_ORRI: dec_c = '{ctrl: CTRL_ORR, illegal: 1'b0};
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_control_pipe.sv
// Pipelined ALU-control decoder between ID and EX: valid/ready stages, flush,
// illegal-opcode flag and saturating illegal counter.
module alu_control_pipe
  import alu_control_pipe_pkg::*;
#(
  parameter int unsigned STAGES  = 1,
  parameter int unsigned EXT_OPS = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  alu_control_pipe_if.slave bus,
  input  logic             flush,
  output logic [CNT_W-1:0] ill_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("alu_control_pipe: STAGES must be 1..4");
  end

  ctrl_word_t dec_c;
  logic       stall_c;
  logic       accept_c;

  alu_control_pipe_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .ALUop  (bus.ALUop),
    .Opcode (bus.Opcode),
    .dec_c  (dec_c)
  );

  // The whole pipe freezes while the last stage waits on EX; bubbles included.
  assign stall_c      = bus.out_valid & ~bus.out_ready;
  assign accept_c     = bus.in_valid & ~stall_c & ~flush;
  assign bus.in_ready = ~stall_c;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic       vld_q;
    ctrl_word_t pay_q;
    logic       vld_in_c;
    ctrl_word_t pay_in_c;

    if (i == 0) begin : g_head
      assign vld_in_c = accept_c;
      assign pay_in_c = dec_c;
    end else begin : g_body
      assign vld_in_c = g_stage[i-1].vld_q;
      assign pay_in_c = g_stage[i-1].pay_q;
    end

    // Flush only drops valid bits; payload is don't-care once invalid.
    always_ff @(posedge CLK) begin
      if (Reset) begin
        vld_q <= 1'b0;
        pay_q <= '0;
      end else if (flush) begin
        vld_q <= 1'b0;
      end else if (!stall_c) begin
        vld_q <= vld_in_c;
        pay_q <= pay_in_c;
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].vld_q;
  assign bus.ALUCtrl   = g_stage[STAGES-1].pay_q.ctrl;
  assign bus.illegal   = g_stage[STAGES-1].pay_q.illegal;

  // Counts illegal entries at accept time; later flushes never undo a count.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ill_count <= '0;
    end else if (accept_c && dec_c.illegal && (ill_count != CNT_MAX)) begin
      ill_count <= ill_count + CNT_W'(1);
    end
  end

endmodule
